// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between dcache and icache: zero-latency grant
// with dcache priority, plus a tag-owner table that routes returning data.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        Dmem_command,
    input  logic [ADDR_W-1:0] Dmem_addr,
    input  logic [1:0]        Dmem_size,
    input  logic [63:0]       Dmem_data,
    input  logic [1:0]        Imem_command,
    input  logic [ADDR_W-1:0] Imem_addr,
    output logic [3:0]        Dmem_response,
    output logic [3:0]        Dmem_tag,
    output logic [63:0]       Dmem_rdata,
    output logic [3:0]        Imem_response,
    output logic [3:0]        Imem_tag,
    output logic [63:0]       Imem_rdata,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [1:0]        proc2mem_size,
    output logic [63:0]       proc2mem_data,
    input  logic [3:0]        mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [3:0]        mem2proc_tag,
    output logic [3:0]        d_outstanding,
    output logic [3:0]        i_outstanding,
    output logic              err_orphan,
    output logic              err_collision
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_ICACHE = 2'd1,
        OWN_DCACHE = 2'd2
    } owner_e;

    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    owner_e     owner_q [1:15];
    owner_e     owner_d [1:15];
    logic [3:0] d_out_q, d_out_d;
    logic [3:0] i_out_q, i_out_d;
    logic       orphan_q, orphan_d;
    logic       collision_q, collision_d;

    logic   d_gnt, i_gnt, alloc, d_inc, d_dec, i_inc, i_dec;
    owner_e ret_owner, alloc_owner, prev_owner;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_size    = '0;
        proc2mem_data    = '0;
        Dmem_response    = '0;
        Imem_response    = '0;
        Dmem_tag         = '0;
        Dmem_rdata       = '0;
        Imem_tag         = '0;
        Imem_rdata       = '0;

        d_gnt = !reset && (Dmem_command != BUS_NONE);
        i_gnt = !reset && !d_gnt && (Imem_command != BUS_NONE);

        if (d_gnt) begin
            proc2mem_command = Dmem_command;
            proc2mem_addr    = Dmem_addr;
            proc2mem_size    = Dmem_size;
            proc2mem_data    = Dmem_data;
            Dmem_response    = mem2proc_response;
        end else if (i_gnt) begin
            proc2mem_command = Imem_command;
            proc2mem_addr    = Imem_addr;
            proc2mem_size    = SIZE_DOUBLE;
            Imem_response    = mem2proc_response;
        end

        ret_owner = OWN_NONE;
        if (mem2proc_tag != '0) ret_owner = owner_q[mem2proc_tag];

        if (!reset && ret_owner == OWN_DCACHE) begin
            Dmem_tag   = mem2proc_tag;
            Dmem_rdata = mem2proc_data;
        end
        if (!reset && ret_owner == OWN_ICACHE) begin
            Imem_tag   = mem2proc_tag;
            Imem_rdata = mem2proc_data;
        end

        alloc = (mem2proc_response != '0) &&
                ((d_gnt && Dmem_command == BUS_LOAD) ||
                 (i_gnt && Imem_command == BUS_LOAD));
        alloc_owner = d_gnt ? OWN_DCACHE : OWN_ICACHE;
        prev_owner  = OWN_NONE;
        if (alloc) prev_owner = owner_q[mem2proc_response];

        // Clear the returning entry first so a same-tag allocation overrides it.
        owner_d = owner_q;
        if (mem2proc_tag != '0) owner_d[mem2proc_tag] = OWN_NONE;
        if (alloc) owner_d[mem2proc_response] = alloc_owner;

        orphan_d    = (mem2proc_tag != '0) && (ret_owner == OWN_NONE);
        collision_d = alloc && (prev_owner != OWN_NONE) &&
                      (mem2proc_tag != mem2proc_response);

        d_inc = alloc && d_gnt;
        d_dec = (ret_owner == OWN_DCACHE);
        i_inc = alloc && i_gnt;
        i_dec = (ret_owner == OWN_ICACHE);

        d_out_d = d_out_q;
        if (d_inc && !d_dec && d_out_q != 4'hF) d_out_d = d_out_q + 4'd1;
        else if (d_dec && !d_inc && d_out_q != 4'h0) d_out_d = d_out_q - 4'd1;

        i_out_d = i_out_q;
        if (i_inc && !i_dec && i_out_q != 4'hF) i_out_d = i_out_q + 4'd1;
        else if (i_dec && !i_inc && i_out_q != 4'h0) i_out_d = i_out_q - 4'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 1; i <= 15; i++) owner_q[i] <= OWN_NONE;
            d_out_q     <= '0;
            i_out_q     <= '0;
            orphan_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            d_out_q     <= d_out_d;
            i_out_q     <= i_out_d;
            orphan_q    <= orphan_d;
            collision_q <= collision_d;
        end
    end

    assign d_outstanding = d_out_q;
    assign i_outstanding = i_out_q;
    assign err_orphan    = orphan_q;
    assign err_collision = collision_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a procedural tag-ownership model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  Dmem_command, Dmem_size, Imem_command;
    logic [15:0] Dmem_addr, Imem_addr;
    logic [63:0] Dmem_data;
    logic [3:0]  Dmem_response, Dmem_tag, Imem_response, Imem_tag;
    logic [63:0] Dmem_rdata, Imem_rdata;
    logic [1:0]  proc2mem_command, proc2mem_size;
    logic [15:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  d_outstanding, i_outstanding;
    logic        err_orphan, err_collision;

    int tests = 0;
    int fails = 0;

    // Reference model: owner per tag (0 none, 1 icache, 2 dcache), counters, error flags
    int m_owner [16];
    int m_d, m_i;
    int m_orphan, m_coll;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(16)) dut (
        .clock(clock), .reset(reset),
        .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_size(Dmem_size),
        .Dmem_data(Dmem_data), .Imem_command(Imem_command), .Imem_addr(Imem_addr),
        .Dmem_response(Dmem_response), .Dmem_tag(Dmem_tag), .Dmem_rdata(Dmem_rdata),
        .Imem_response(Imem_response), .Imem_tag(Imem_tag), .Imem_rdata(Imem_rdata),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag), .d_outstanding(d_outstanding),
        .i_outstanding(i_outstanding), .err_orphan(err_orphan),
        .err_collision(err_collision)
    );

    task automatic drive(input logic [1:0] dc, input logic [15:0] da, input logic [1:0] ds,
                         input logic [63:0] dd, input logic [1:0] ic, input logic [15:0] ia,
                         input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
        Dmem_command = dc; Dmem_addr = da; Dmem_size = ds; Dmem_data = dd;
        Imem_command = ic; Imem_addr = ia;
        mem2proc_response = mr; mem2proc_tag = mt; mem2proc_data = md;
        #2;
    endtask

    task automatic idle(input logic [3:0] mt, input logic [63:0] md);
        drive(2'd0, 16'h0, 2'd0, 64'h0, 2'd0, 16'h0, 4'd0, mt, md);
    endtask

    // Advance one clock and apply the arbiter's rules to the model.
    task automatic tick();
        bit dg, ig, alloc;
        int who, r, t;
        @(posedge clock);
        r = int'(mem2proc_response);
        t = int'(mem2proc_tag);
        if (reset) begin
            for (int k = 0; k < 16; k++) m_owner[k] = 0;
            m_d = 0; m_i = 0; m_orphan = 0; m_coll = 0;
        end else begin
            dg = (Dmem_command != 2'd0);
            ig = !dg && (Imem_command != 2'd0);
            who = dg ? 2 : 1;
            alloc = (r != 0) && ((dg && Dmem_command == 2'd1) || (ig && Imem_command == 2'd1));
            m_orphan = (t != 0 && m_owner[t] == 0) ? 1 : 0;
            m_coll   = (alloc && m_owner[r] != 0 && t != r) ? 1 : 0;
            if (alloc && who == 2 && !(t != 0 && m_owner[t] == 2)) m_d = (m_d < 15) ? m_d + 1 : 15;
            if (!(alloc && who == 2) && t != 0 && m_owner[t] == 2) m_d = (m_d > 0) ? m_d - 1 : 0;
            if (alloc && who == 1 && !(t != 0 && m_owner[t] == 1)) m_i = (m_i < 15) ? m_i + 1 : 15;
            if (!(alloc && who == 1) && t != 0 && m_owner[t] == 1) m_i = (m_i > 0) ? m_i - 1 : 0;
            if (t != 0) m_owner[t] = 0;
            if (alloc) m_owner[r] = who;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'd1, 16'h1111, 2'd3, 64'h55, 2'd1, 16'h2222, 4'd6, 4'd6, 64'hAA);
        tests++;
        if ({proc2mem_command, Dmem_response, Imem_response, Dmem_tag, Imem_tag} !== 18'h0) begin
            fails++; $display("FAIL reset_outputs: got cmd=%0d dr=%0d ir=%0d dt=%0d it=%0d exp all 0",
                              proc2mem_command, Dmem_response, Imem_response, Dmem_tag, Imem_tag);
        end
        tests++;
        if ({Dmem_rdata, Imem_rdata} !== 128'h0) begin
            fails++; $display("FAIL reset_rdata: got %h %h exp 0", Dmem_rdata, Imem_rdata);
        end
        tick(); tick();
        reset = 1'b0;
        idle(4'd0, 64'h0);
        tests++;
        if ({d_outstanding, i_outstanding, err_orphan, err_collision} !== 10'h0) begin
            fails++; $display("FAIL reset_state: got d=%0d i=%0d o=%b c=%b exp 0",
                              d_outstanding, i_outstanding, err_orphan, err_collision);
        end
    endtask

    task automatic test_priority();
        drive(2'd1, 16'h0040, 2'd3, 64'h0, 2'd1, 16'h1000, 4'd3, 4'd0, 64'h0);
        tests++;
        if (proc2mem_addr !== 16'h0040 || proc2mem_command !== 2'd1) begin
            fails++; $display("FAIL prio_port: got addr=%h cmd=%0d exp 0040/1", proc2mem_addr, proc2mem_command);
        end
        tests++;
        if (Dmem_response !== 4'd3 || Imem_response !== 4'd0) begin
            fails++; $display("FAIL prio_resp: got d=%0d i=%0d exp 3/0", Dmem_response, Imem_response);
        end
        tick();
        idle(4'd0, 64'h0);
        tests++;
        if (d_outstanding !== 4'd1 || i_outstanding !== 4'd0) begin
            fails++; $display("FAIL prio_count: got d=%0d i=%0d exp 1/0", d_outstanding, i_outstanding);
        end
    endtask

    task automatic test_icache_return();
        drive(2'd0, 16'h0, 2'd0, 64'h0, 2'd1, 16'h2000, 4'd5, 4'd0, 64'h0);
        tests++;
        if (proc2mem_addr !== 16'h2000 || proc2mem_size !== 2'd3 || proc2mem_data !== 64'h0 ||
            Imem_response !== 4'd5 || Dmem_response !== 4'd0) begin
            fails++; $display("FAIL ifetch_grant: got addr=%h size=%0d data=%h ir=%0d dr=%0d exp 2000/3/0/5/0",
                              proc2mem_addr, proc2mem_size, proc2mem_data, Imem_response, Dmem_response);
        end
        tick();
        idle(4'd0, 64'h0);
        tests++;
        if (i_outstanding !== 4'd1) begin
            fails++; $display("FAIL ifetch_count_up: got %0d exp 1", i_outstanding);
        end
        idle(4'd5, 64'hDEADBEEF_CAFEF00D);
        tests++;
        if (Imem_tag !== 4'd5 || Imem_rdata !== 64'hDEADBEEF_CAFEF00D || Dmem_tag !== 4'd0 || Dmem_rdata !== 64'h0) begin
            fails++; $display("FAIL ifetch_route: got it=%0d id=%h dt=%0d dd=%h exp 5/deadbeefcafef00d/0/0",
                              Imem_tag, Imem_rdata, Dmem_tag, Dmem_rdata);
        end
        tick();
        idle(4'd0, 64'h0);
        tests++;
        if (i_outstanding !== 4'd0 || err_orphan !== 1'b0) begin
            fails++; $display("FAIL ifetch_count_down: got i=%0d o=%b exp 0/0", i_outstanding, err_orphan);
        end
    endtask

    task automatic test_store();
        int d_before;
        d_before = m_d;
        drive(2'd2, 16'h0080, 2'd2, 64'h1234, 2'd1, 16'h3000, 4'd7, 4'd0, 64'h0);
        tests++;
        if (proc2mem_command !== 2'd2 || proc2mem_size !== 2'd2 || proc2mem_data !== 64'h1234 ||
            Dmem_response !== 4'd7 || Imem_response !== 4'd0) begin
            fails++; $display("FAIL store_port: got cmd=%0d size=%0d data=%h dr=%0d ir=%0d exp 2/2/1234/7/0",
                              proc2mem_command, proc2mem_size, proc2mem_data, Dmem_response, Imem_response);
        end
        tick();
        idle(4'd7, 64'h77);
        tests++;
        if (int'(d_outstanding) !== d_before || Dmem_tag !== 4'd0) begin
            fails++; $display("FAIL store_noalloc: got d=%0d dt=%0d exp %0d/0", d_outstanding, Dmem_tag, d_before);
        end
        tick();
        idle(4'd0, 64'h0);
        tests++;
        if (err_orphan !== 1'b1) begin
            fails++; $display("FAIL store_tag_orphan: got %b exp 1", err_orphan);
        end
    endtask

    task automatic test_same_tag();
        int d0, i0;
        drive(2'd1, 16'h0400, 2'd3, 64'h0, 2'd0, 16'h0, 4'd4, 4'd0, 64'h0);
        tick();
        d0 = m_d; i0 = m_i;
        drive(2'd0, 16'h0, 2'd0, 64'h0, 2'd1, 16'h4400, 4'd4, 4'd4, 64'h0123_4567_89AB_CDEF);
        tests++;
        if (Dmem_tag !== 4'd4 || Dmem_rdata !== 64'h0123_4567_89AB_CDEF || Imem_tag !== 4'd0 || Imem_response !== 4'd4) begin
            fails++; $display("FAIL sametag_route: got dt=%0d dd=%h it=%0d ir=%0d exp 4/0123456789abcdef/0/4",
                              Dmem_tag, Dmem_rdata, Imem_tag, Imem_response);
        end
        tick();
        idle(4'd4, 64'h44);
        tests++;
        if (err_orphan !== 1'b0 || err_collision !== 1'b0 ||
            int'(d_outstanding) !== d0 - 1 || int'(i_outstanding) !== i0 + 1) begin
            fails++; $display("FAIL sametag_state: got o=%b c=%b d=%0d i=%0d exp 0/0/%0d/%0d",
                              err_orphan, err_collision, d_outstanding, i_outstanding, d0 - 1, i0 + 1);
        end
        tests++;
        if (Imem_tag !== 4'd4 || Dmem_tag !== 4'd0) begin
            fails++; $display("FAIL sametag_newowner: got it=%0d dt=%0d exp 4/0", Imem_tag, Dmem_tag);
        end
        tick();
    endtask

    task automatic test_orphan();
        idle(4'd9, 64'h99);
        tests++;
        if (Dmem_tag !== 4'd0 || Imem_tag !== 4'd0) begin
            fails++; $display("FAIL orphan_route: got dt=%0d it=%0d exp 0/0", Dmem_tag, Imem_tag);
        end
        tick();
        idle(4'd0, 64'h0);
        tests++;
        if (err_orphan !== 1'b1) begin
            fails++; $display("FAIL orphan_pulse: got %b exp 1", err_orphan);
        end
        tick();
        tests++;
        if (err_orphan !== 1'b0) begin
            fails++; $display("FAIL orphan_one_cycle: got %b exp 0", err_orphan);
        end
    endtask

    task automatic test_collision();
        int d0, i0;
        drive(2'd1, 16'h0A00, 2'd3, 64'h0, 2'd0, 16'h0, 4'd10, 4'd0, 64'h0);
        tick();
        d0 = m_d; i0 = m_i;
        drive(2'd0, 16'h0, 2'd0, 64'h0, 2'd1, 16'hA000, 4'd10, 4'd0, 64'h0);
        tick();
        idle(4'd10, 64'hA0A0);
        tests++;
        if (err_collision !== 1'b1 || int'(d_outstanding) !== d0 || int'(i_outstanding) !== i0 + 1) begin
            fails++; $display("FAIL collision_pulse: got c=%b d=%0d i=%0d exp 1/%0d/%0d",
                              err_collision, d_outstanding, i_outstanding, d0, i0 + 1);
        end
        tests++;
        if (Imem_tag !== 4'd10 || Dmem_tag !== 4'd0) begin
            fails++; $display("FAIL collision_overwrite: got it=%0d dt=%0d exp 10/0", Imem_tag, Dmem_tag);
        end
        tick();
        tests++;
        if (err_collision !== 1'b0) begin
            fails++; $display("FAIL collision_one_cycle: got %b exp 0", err_collision);
        end
    endtask

    task automatic test_reset_midflight();
        drive(2'd1, 16'h0B00, 2'd3, 64'h0, 2'd0, 16'h0, 4'd11, 4'd0, 64'h0);
        tick();
        drive(2'd0, 16'h0, 2'd0, 64'h0, 2'd1, 16'hC000, 4'd12, 4'd0, 64'h0);
        tick();
        reset = 1'b1;
        drive(2'd1, 16'h0D00, 2'd3, 64'h0, 2'd1, 16'hD000, 4'd13, 4'd11, 64'h1);
        tests++;
        if (proc2mem_command !== 2'd0 || Dmem_response !== 4'd0 || Imem_response !== 4'd0 || Dmem_tag !== 4'd0) begin
            fails++; $display("FAIL rstmid_outputs: got cmd=%0d dr=%0d ir=%0d dt=%0d exp 0",
                              proc2mem_command, Dmem_response, Imem_response, Dmem_tag);
        end
        tick();
        reset = 1'b0;
        idle(4'd11, 64'hB);
        tests++;
        if (d_outstanding !== 4'd0 || i_outstanding !== 4'd0 || Dmem_tag !== 4'd0) begin
            fails++; $display("FAIL rstmid_state: got d=%0d i=%0d dt=%0d exp 0/0/0", d_outstanding, i_outstanding, Dmem_tag);
        end
        tick();
        idle(4'd0, 64'h0);
        tests++;
        if (err_orphan !== 1'b1) begin
            fails++; $display("FAIL rstmid_orphan: got %b exp 1", err_orphan);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 16; k++) begin
            drive(2'd1, 16'(k), 2'd3, 64'h0, 2'd0, 16'h0, 4'((k % 15) + 1), 4'd0, 64'h0);
            tick();
        end
        idle(4'd0, 64'h0);
        tests++;
        if (d_outstanding !== 4'd15 || err_collision !== 1'b1) begin
            fails++; $display("FAIL saturate_high: got d=%0d c=%b exp 15/1", d_outstanding, err_collision);
        end
    endtask

    task automatic test_random();
        logic [1:0]  dc, ds, ic, e_cmd, e_size;
        logic [15:0] da, ia, e_addr;
        logic [63:0] dd, md, e_data;
        logic [3:0]  mr, mt, e_dr, e_ir, e_dt, e_it;
        bit dg, ig;
        int own;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            dc = 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
            ic = 2'($urandom_range(0, 1));
            ds = 2'($urandom); da = 16'($urandom); ia = 16'($urandom);
            dd = {$urandom, $urandom}; md = {$urandom, $urandom};
            mr = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mt = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            drive(dc, da, ds, dd, ic, ia, mr, mt, md);

            dg = !reset && dc != 2'd0;
            ig = !reset && !dg && ic != 2'd0;
            e_cmd  = dg ? dc : (ig ? ic : 2'd0);
            e_addr = dg ? da : (ig ? ia : 16'h0);
            e_size = dg ? ds : (ig ? 2'd3 : 2'd0);
            e_data = dg ? dd : 64'h0;
            e_dr = dg ? mr : 4'd0;
            e_ir = ig ? mr : 4'd0;
            own = (reset || mt == 4'd0) ? 0 : m_owner[mt];
            e_dt = (own == 2) ? mt : 4'd0;
            e_it = (own == 1) ? mt : 4'd0;
            tests++;
            if ({proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data} !== {e_cmd, e_addr, e_size, e_data}) begin
                fails++; $display("FAIL rand_port[%0d]: got %0d/%h/%0d/%h exp %0d/%h/%0d/%h", n,
                                  proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data, e_cmd, e_addr, e_size, e_data);
            end
            tests++;
            if ({Dmem_response, Imem_response, Dmem_tag, Imem_tag} !== {e_dr, e_ir, e_dt, e_it} ||
                Dmem_rdata !== ((own == 2) ? md : 64'h0) || Imem_rdata !== ((own == 1) ? md : 64'h0)) begin
                fails++; $display("FAIL rand_route[%0d]: got dr=%0d ir=%0d dt=%0d it=%0d exp %0d/%0d/%0d/%0d", n,
                                  Dmem_response, Imem_response, Dmem_tag, Imem_tag, e_dr, e_ir, e_dt, e_it);
            end
            tick();
            tests++;
            if (int'(d_outstanding) !== m_d || int'(i_outstanding) !== m_i ||
                int'(err_orphan) !== m_orphan || int'(err_collision) !== m_coll) begin
                fails++; $display("FAIL rand_state[%0d]: got d=%0d i=%0d o=%b c=%b exp %0d/%0d/%0d/%0d", n,
                                  d_outstanding, i_outstanding, err_orphan, err_collision, m_d, m_i, m_orphan, m_coll);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) m_owner[k] = 0;
        m_d = 0; m_i = 0; m_orphan = 0; m_coll = 0;
        reset = 1'b1;
        idle(4'd0, 64'h0);
        @(posedge clock); #1;
        test_reset();
        test_priority();
        test_icache_return();
        test_store();
        test_same_tag();
        test_orphan();
        test_collision();
        test_reset_midflight();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
